// File: rtl/sodor3_instr_sequencer_pkg.sv
// Shared constants, state encoding and LFSR step for the Sodor3 lockstep stimulus.
package sodor3_verif_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [31:0] INSTR_NOP  = 32'h00000013;
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    // Galois right-shift step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Shift-immediate legality: SLLI keeps shamt, SRLI/SRAI keep shamt plus the arithmetic bit.
    function automatic logic [11:0] alu_imm(input logic [11:0] imm, input logic [2:0] f3);
        logic [11:0] r;
        r = imm;
        if (f3 == 3'd1) begin
            r = imm & 12'h01F;
        end else if (f3 == 3'd5) begin
            r = imm & 12'h41F;
        end
        return r;
    endfunction

endpackage

// File: rtl/sodor3_instr_sequencer_if.sv
// Instruction issue channel between the sequencer and the core/model consumers.
interface sodor3_instr_sequencer_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        is_load;

    modport master (
        output instr_valid,
        output instr,
        output is_load,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  is_load,
        output instr_ready
    );

endinterface

// File: rtl/sodor3_instr_sequencer_lfsr32.sv
// 32-bit Galois LFSR, reset to a seed (zero seed mapped to 1), stepped on advance.
module sodor3_lfsr32
    import sodor3_verif_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] seed_eff;
    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        seed_eff = (seed == '0) ? 32'h00000001 : seed;
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= seed_eff;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sodor3_instr_sequencer.sv
// Bounded, back-pressurable random ALU/byte-load stream followed by a NOP drain.
module sodor3_instr_sequencer
    import sodor3_verif_pkg::*;
#(
    parameter int unsigned NUM_INSTR    = 100,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter logic [31:0] SEED         = 32'h000117E4,
    parameter bit          LOAD_EN      = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    sodor3_instr_sequencer_if.master        bus,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     issued_count
);

    localparam logic [15:0] NUM_W   = NUM_INSTR[15:0];
    localparam logic [7:0]  DRAIN_W = DRAIN_CYCLES[7:0];

    seq_state_e  state_q, state_d;
    logic [15:0] issued_q, issued_d, issued_inc;
    logic [7:0]  drain_q, drain_d, drain_inc;
    logic        advance;
    logic [31:0] lfsr;

    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        choice;
    logic [31:0] rand_instr;
    logic        rand_is_load;

    sodor3_lfsr32 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (SEED),
        .advance (advance),
        .state   (lfsr)
    );

    always_comb begin
        imm    = lfsr[31:20];
        rs1    = lfsr[19:15];
        f3     = lfsr[14:12];
        rd     = lfsr[11:7];
        choice = lfsr[0] | ~LOAD_EN;
        if (choice) begin
            rand_instr   = {alu_imm(imm, f3), rs1, f3, rd, OPC_OP_IMM};
            rand_is_load = 1'b0;
        end else begin
            rand_instr   = {imm, rs1, {f3[2], 2'b00}, rd, OPC_LOAD};
            rand_is_load = 1'b1;
        end
    end

    assign issued_inc = issued_q + 16'd1;
    assign drain_inc  = drain_q + 8'd1;

    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        drain_d         = drain_q;
        advance         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = INSTR_NOP;
        bus.is_load     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    issued_d = '0;
                    drain_d  = '0;
                    state_d  = (NUM_W != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                bus.instr_valid = 1'b1;
                bus.instr       = rand_instr;
                bus.is_load     = rand_is_load;
                if (bus.instr_ready) begin
                    advance  = 1'b1;
                    issued_d = issued_inc;
                    if (issued_inc == NUM_W) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    drain_d = drain_inc;
                    if (drain_inc == DRAIN_W) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            issued_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            drain_q  <= drain_d;
        end
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign issued_count = issued_q;

endmodule

// File: doc/sodor3_instr_sequencer.md
Name: sodor3_instr_sequencer

Overview:
- Constrained-random instruction sequencer for Sodor3 lockstep verification. It feeds the shared instruction stream to both the core (coretop) and the model (s3m).
- Each instruction is either an I-type ALU op or a byte load (LB/LBU), drawn from a seeded 32-bit LFSR.
- Issue uses a valid/ready handshake, then a fixed NOP drain so both pipelines retire before `done`.
- Replaces the free-running per-cycle stimulus with a sequenced, back-pressurable, bounded run.

Parameters:
- NUM_INSTR, 100, random instructions issued per run; legal range 0..65535.
- DRAIN_CYCLES, 8, NOPs issued after the random phase; legal range 1..255.
- SEED, 32'h000117E4, LFSR reset value; 0 is replaced by 32'h00000001.
- LOAD_EN, 1, when 0 every instruction is ALU (choice bit forced to 1).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a run from IDLE or DONE, ignored otherwise.
- instr_ready  input  1  consumer accepts instr this cycle.
- instr_valid  output  1  instr is valid.
- instr  output  32  instruction word.
- is_load  output  1  instr is a load (0 in IDLE/DRAIN/DONE).
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is DONE.
- issued_count  output  16  random instructions accepted in this run.

Behaviour:
- Reset (async) values:
  - state=IDLE, LFSR=SEED (or 1 if SEED is 0).
  - instr_valid=0, instr=32'h00000013, is_load=0, busy=0, done=0, issued_count=0.
  - Reset asserted mid-run aborts immediately to these values; no partial drain.
- Handshake:
  - A transfer occurs on the rising edge where instr_valid && instr_ready.
  - While valid is high and ready is low, instr, is_load and the LFSR hold stable.
  - The LFSR advances exactly once per accepted RUN transfer.
- LFSR:
  - Galois, shift right, taps 32'h80200003.
  - Next state = (s>>1) ^ (s[0] ? TAPS : 0).
- Field extraction from current state s:
  - imm=s[31:20], rs1=s[19:15], f3=s[14:12], rd=s[11:7].
  - choice=s[0] | ~LOAD_EN.
- ALU instruction (choice=1): {imm', rs1, f3, rd, 7'b0010011}.
  - f3=1 gives imm' = imm & 12'h01F.
  - f3=5 gives imm' = imm & 12'h41F.
  - Otherwise imm' = imm.
- Load instruction (choice=0): {imm, rs1, {f3[2],2'b00}, rd, 7'b0000011}, with is_load=1.
- Outputs are registered-state driven, combinational from state and LFSR. No cycle of latency between state change and instr.
- FSM:
  - IDLE: valid=0, instr=NOP.
    - start with NUM_INSTR>0 goes to RUN; with NUM_INSTR==0 goes to DRAIN.
    - On start, issued_count and drain counter clear.
  - RUN: valid=1, instr=random.
    - Each transfer increments issued_count.
    - The transfer that makes issued_count==NUM_INSTR goes to DRAIN.
  - DRAIN: valid=1, instr=32'h00000013.
    - An 8-bit drain counter counts transfers.
    - The DRAIN_CYCLES-th transfer goes to DONE.
  - DONE: valid=0, instr=NOP, done=1, issued_count held.
    - start re-arms as in IDLE.
    - The LFSR is not reseeded, so the sequence continues.
- start while busy has no effect. start and reset together: reset wins.
- issued_count never wraps; NUM_INSTR bounds it.

Decomposition:
- Package sodor3_verif_pkg holds:
  - OPC_OP_IMM=7'b0010011, OPC_LOAD=7'b0000011, INSTR_NOP=32'h00000013.
  - LFSR_TAPS=32'h80200003.
  - State enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module sodor3_lfsr32:
  - Ports: clk, reset, seed, advance, state.
  - Async reset to seed (with the 0 guard); steps on advance.
- Top module holds the FSM, counters and field-constraint logic.

Test Plan:
- Reset value check: hold reset with SEED default -> instr_valid=0, instr=32'h00000013, busy=0, done=0, issued_count=0.
- First instruction: start, ready=1 -> first instr=32'h00010783 (LB x15,0(x2)), is_load=1; issued_count=1 after the edge.
- Backpressure: start, ready=0 for 3 cycles -> instr stable at 32'h00010783 and LFSR unchanged; ready=1 -> transfer, next instr differs.
- Bounded run: NUM_INSTR=4, DRAIN_CYCLES=2, ready=1 -> exactly 4 non-NOP transfers, then 2 NOP transfers. done=1 on the cycle after the 6th transfer; issued_count=4.
- Immediate constraints: 10000 transfers with LOAD_EN=1 ->
  - ALU with f3=1: instr[31:25]=0.
  - ALU with f3=5: instr[31:25] is 7'h00 or 7'h20.
  - Loads: instr[13:12]=0.
  - Both ALU and load observed.
- Reset mid-run: assert reset after 2 transfers -> same-cycle IDLE values. A new start reproduces 32'h00010783 as the first instruction.
